// File: rtl/phase_sampler_pkg.sv
// ---------------------------------------------------------------------------
// phase_sampler_pkg
// Shared types and constants for the phase sampler block:
//   state_e    output FSM states (IDLE, SEND)
//   ph_idx_t   2-bit phase / channel index
//   NUM_PH     number of strobe phases (4)
//   PH_LAST    index of the phase whose capture closes a frame (3)
//   lowest_set helper returning the lowest set bit index of a phase vector
// ---------------------------------------------------------------------------
package phase_sampler_pkg;

  localparam int NUM_PH  = 4;
  localparam int PH_LAST = 3;

  typedef logic [1:0] ph_idx_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic ph_idx_t lowest_set(input logic [NUM_PH-1:0] v);
    ph_idx_t idx;
    idx = '0;
    for (int i = NUM_PH - 1; i >= 0; i--) begin
      if (v[i]) idx = ph_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/phase_sampler_edge_sync.sv
// ---------------------------------------------------------------------------
// phase_edge_sync
// Two-flop synchronizer followed by a rising-edge detector, W bits wide.
// rise_o pulses for one clock, two clocks after an input rises.
// Ports:
//   clk_i    clock (rising edge)
//   rst_i    synchronous, active-high reset
//   async_i  asynchronous strobes
//   rise_o   one-cycle rising-edge pulses (sync2 & ~sync3)
// ---------------------------------------------------------------------------
module phase_edge_sync #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] sync1_q, sync2_q, sync3_q;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/phase_sampler.sv
// ---------------------------------------------------------------------------
// phase_sampler
// Samples the shared ADC bus on the rising edge of each phase strobe C0..C3,
// averages each channel over 2^AVG_LOG2 frames and streams the four results
// out over a valid/ready port.
// Optional build macro: PHASE_SAMPLER_SEQ_CHECK_EN enables phase-order
// checking (SEQ_ERR); without it SEQ_ERR is tied low.
// Ports:
//   OSC        clock (rising edge)
//   RES_HARD   synchronous, active-high reset
//   C0..C3     phase strobes; a C3 capture closes a frame
//   ADC_DATA   converter sample, stable while a strobe is high
//   DATA_OUT   averaged sample       CH_OUT    channel index of DATA_OUT
//   VALID_OUT  transfer valid        READY_IN  consumer accepts transfer
//   OVERRUN    sticky: a result set was dropped
//   SEQ_ERR    sticky: phase-order error
// ---------------------------------------------------------------------------
module phase_sampler
  import phase_sampler_pkg::*;
#(
  parameter int DW       = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic          OSC,
  input  logic          RES_HARD,
  input  logic          C0,
  input  logic          C1,
  input  logic          C2,
  input  logic          C3,
  input  logic [DW-1:0] ADC_DATA,
  output logic [DW-1:0] DATA_OUT,
  output logic [1:0]    CH_OUT,
  output logic          VALID_OUT,
  input  logic          READY_IN,
  output logic          OVERRUN,
  output logic          SEQ_ERR
);

  localparam int ACW = DW + AVG_LOG2;
  localparam int FCW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'((1 << AVG_LOG2) - 1);

  logic [NUM_PH-1:0] rise;
  logic [NUM_PH-1:0] cap;
  logic              seq_bad;

  phase_edge_sync #(.W(NUM_PH)) u_edge_sync (
    .clk_i   (OSC),
    .rst_i   (RES_HARD),
    .async_i ({C3, C2, C1, C0}),
    .rise_o  (rise)
  );

`ifdef PHASE_SAMPLER_SEQ_CHECK_EN
  ph_idx_t exp_ph_q, exp_ph_d;
  logic    seq_err_q, seq_err_d;

  // Any edge other than the single expected one discards the capture.
  always_comb begin
    seq_bad   = (rise != '0) && (rise != (NUM_PH'(1) << exp_ph_q));
    cap       = seq_bad ? '0 : rise;
    exp_ph_d  = exp_ph_q;
    seq_err_d = seq_err_q | seq_bad;
    if (seq_bad)          exp_ph_d = lowest_set(rise) + ph_idx_t'(1);
    else if (rise != '0)  exp_ph_d = exp_ph_q + ph_idx_t'(1);
  end

  always_ff @(posedge OSC) begin
    if (RES_HARD) begin
      exp_ph_q  <= '0;
      seq_err_q <= 1'b0;
    end else begin
      exp_ph_q  <= exp_ph_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign SEQ_ERR = seq_err_q;
`else
  assign seq_bad = 1'b0;
  assign cap     = rise;
  assign SEQ_ERR = 1'b0;
`endif

  // Datapath state
  logic [ACW-1:0] acc_q [NUM_PH];
  logic [ACW-1:0] acc_d [NUM_PH];
  logic [ACW-1:0] sum   [NUM_PH];
  logic [DW-1:0]  out_buf_q [NUM_PH];
  logic [DW-1:0]  out_buf_d [NUM_PH];
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           pending_q, pending_d;
  logic           overrun_q, overrun_d;
  logic           frame_end;

  // FSM state
  state_e  state_q, state_d;
  ph_idx_t ch_q, ch_d;

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    frame_end   = cap[PH_LAST] && (frame_cnt_q == FRAME_LAST);
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    for (int n = 0; n < NUM_PH; n++) begin
      sum[n]       = acc_q[n] + (cap[n] ? ACW'(ADC_DATA) : '0);
      acc_d[n]     = sum[n];
      out_buf_d[n] = out_buf_q[n];
    end

    if (cap[PH_LAST]) frame_cnt_d = frame_end ? '0 : frame_cnt_q + FCW'(1);

    // Sum includes this cycle's sample, so the C3 of the last frame counts.
    if (frame_end) begin
      for (int n = 0; n < NUM_PH; n++) acc_d[n] = '0;
      if (state_q == IDLE && !pending_q) begin
        for (int n = 0; n < NUM_PH; n++) out_buf_d[n] = DW'(sum[n] >> AVG_LOG2);
        pending_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (seq_bad) begin
      for (int n = 0; n < NUM_PH; n++) acc_d[n] = '0;
      frame_cnt_d = '0;
    end

    // Load never coincides with this: it requires pending_q low.
    if (state_q == IDLE && pending_q) pending_d = 1'b0;
  end

  // NOTE: the output buffer is only four words and must read as zero after
  // reset, so it is reset like plain flops rather than treated as a RAM.
  always_ff @(posedge OSC) begin
    if (RES_HARD) begin
      for (int n = 0; n < NUM_PH; n++) begin
        acc_q[n]     <= '0;
        out_buf_q[n] <= '0;
      end
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_PH; n++) begin
        acc_q[n]     <= acc_d[n];
        out_buf_q[n] <= out_buf_d[n];
      end
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

  // FSM: state register
  always_ff @(posedge OSC) begin
    if (RES_HARD) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = SEND;
          ch_d    = '0;
        end
      end
      SEND: begin
        if (READY_IN) begin
          if (ch_q == ph_idx_t'(PH_LAST)) state_d = IDLE;
          else                            ch_d    = ch_q + ph_idx_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    VALID_OUT = 1'b0;
    CH_OUT    = '0;
    DATA_OUT  = '0;
    if (state_q == SEND) begin
      VALID_OUT = 1'b1;
      CH_OUT    = ch_q;
      DATA_OUT  = out_buf_q[ch_q];
    end
  end

  assign OVERRUN = overrun_q;

endmodule
